regfile_hilo_sb: RTL and testbench
==================================

// Module: regfile_hilo_sb
// PURPOSE
// - Next-generation integer register file for the MIPS core: GPR array plus a HI/LO pair.
// - Parametrised data width, register count and GPR read-port count; writes on posedge clk.
// - Same-cycle write-to-read bypass on every read port.
// - Outstanding-claim scoreboard on HI/LO: the decode stage stalls mfhi/mflo until every
//   in-flight mult/div result has retired.
// PARAMETERS
// DW        32  data width of each GPR, HI and LO
// NREG      32  number of GPRs; AW = $clog2(NREG); register 0 reads as 0
// NRD       2   number of GPR read ports
// MAX_PEND  3   maximum outstanding HI/LO claims; CW = $clog2(MAX_PEND+1)
// PORTS
// clk         in   1       clock, all state updates on rising edge
// resetn      in   1       asynchronous active-low reset
// ra          in   NRD*AW  read addresses, port i = ra[i*AW +: AW]
// rd          out  NRD*DW  read data, port i = rd[i*DW +: DW], combinational
// we          in   1       GPR write enable
// wa          in   AW      GPR write address
// wd          in   DW      GPR write data
// hilo_we     in   2       bit1 = write HI, bit0 = write LO
// hilo_wd     in   2*DW    {HI, LO} write data
// hi_rd       out  DW      HI read data (bypassed)
// lo_rd       out  DW      LO read data (bypassed)
// hilo_claim  in   1       a mult/div issued; it will write HI/LO later
// hilo_rel    in   1       a claimed op has retired; normally pulsed with its hilo_we
// hilo_busy   out  1       pend_cnt != 0
// pend_cnt    out  CW      outstanding claim count
// claim_ovf   out  1       registered 1-cycle pulse: claim dropped at MAX_PEND
// BEHAVIOUR
// - Reset (async, resetn=0):
//   - all GPRs, HI and LO := 0; pend_cnt := 0; claim_ovf := 0.
//   - Combinational outputs follow immediately: rd = 0, hi_rd = lo_rd = 0, hilo_busy = 0.
// - GPR write:
//   - we && wa != 0: rf[wa] := wd at posedge. Writes to register 0 are discarded.
//   - wa >= NREG: write discarded; reads of an address >= NREG return 0.
// - GPR read, per port i:
//   - ra_i == 0: rd_i = 0.
//   - else we && wa == ra_i: rd_i = wd (bypass).
//   - else rd_i = rf[ra_i].
//   - Zero-cycle latency; identical addresses on several ports are legal.
// - HI/LO write:
//   - hilo_we[1]: HI := hilo_wd[2*DW-1:DW]. hilo_we[0]: LO := hilo_wd[DW-1:0].
//   - Either or both may be set in a cycle.
// - HI/LO read:
//   - hi_rd = hilo_we[1] ? hilo_wd[2*DW-1:DW] : HI; lo_rd likewise with bit 0.
//   - GPR and HI/LO write ports are independent; both may fire in the same cycle.
// - Scoreboard (registered), per cycle:
//   - claim only: pend_cnt +1, unless pend_cnt == MAX_PEND. In that case pend_cnt holds and
//     claim_ovf = 1 in the next cycle.
//   - rel only: pend_cnt -1, unless pend_cnt == 0. Underflow is ignored and pend_cnt stays 0.
//   - claim && rel:
//     - pend_cnt unchanged, including at 0 and at MAX_PEND.
//     - Never ovf.
//   - neither: hold.
//   - claim_ovf deasserts the cycle after any non-overflow cycle.
// - hilo_busy:
//   - Derived from the registered pend_cnt; it does NOT see a same-cycle rel.
//   - Decode must therefore stall one extra cycle after the last release.
//   - This is deliberate, to keep the stall path short.
// TESTING
// T1 reset: load r5=0xDEADBEEF, HI=1, pend_cnt=2, then pulse resetn=0 mid-cycle ->
//    rd, hi_rd, lo_rd, pend_cnt, hilo_busy all 0 before the next edge.
// T2 bypass: we=1, wa=7, wd=0x12345678, ra0=ra1=7 in the same cycle -> rd0=rd1=0x12345678.
//    Next cycle with we=0 -> still 0x12345678 from the array.
// T3 r0: we=1, wa=0, wd=0xFFFFFFFF -> ra0=0 returns 0 that cycle and afterwards.
// T4 HI/LO masks:
//    - hilo_we=2'b10, hilo_wd={0xAAAA0000,0x5555} -> HI=0xAAAA0000, LO unchanged (0).
//    - Then hilo_we=2'b11 with {1,2} -> HI=1, LO=2; hi_rd/lo_rd show the new values
//      in the write cycle.
// T5 scoreboard saturation:
//    - 4 consecutive claims (MAX_PEND=3) -> pend_cnt=1,2,3,3 and claim_ovf high one cycle
//      after the 4th claim.
//    - Then claim&&rel -> stays 3.
//    - Then 4 rels -> pend_cnt=2,1,0,0 and hilo_busy low after the 3rd rel edge.
// T6 random: 10k cycles of random we/wa/ra/hilo traffic against a reference model.
//    - Compare rd, hi_rd, lo_rd and pend_cnt every cycle.
//    - Assert pend_cnt <= MAX_PEND always.

Source files
------------

// File: rtl/regfile_hilo_sb.sv
// regfile_hilo_sb
//   Integer register file for the MIPS core: a GPR array with NRD combinational
//   read ports and one write port, a HI/LO register pair, and a small
//   outstanding-claim scoreboard that the decode stage uses to stall mfhi/mflo
//   while mult/div results are still in flight.
//
// Ports
//   clk         clock, every state update on the rising edge
//   resetn      asynchronous active-low reset
//   ra / rd     packed read addresses / read data, port i at [i*AW +: AW] / [i*DW +: DW]
//   we/wa/wd    GPR write port (register 0 is hard-wired to zero)
//   hilo_we     {write HI, write LO}
//   hilo_wd     {HI, LO} write data
//   hi_rd/lo_rd HI/LO read data, bypassed from a same-cycle write
//   hilo_claim  a mult/div was issued and will write HI/LO later
//   hilo_rel    a claimed op retired
//   hilo_busy   at least one claim outstanding (registered count only)
//   pend_cnt    outstanding claim count
//   claim_ovf   one-cycle pulse: a claim arrived while the count was full
module regfile_hilo_sb #(
  parameter int DW       = 32,
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter int MAX_PEND = 3,
  localparam int AW      = $clog2(NREG),
  localparam int CW      = $clog2(MAX_PEND + 1)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*DW-1:0]   rd,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [DW-1:0]       wd,
  input  logic [1:0]          hilo_we,
  input  logic [2*DW-1:0]     hilo_wd,
  output logic [DW-1:0]       hi_rd,
  output logic [DW-1:0]       lo_rd,
  input  logic                hilo_claim,
  input  logic                hilo_rel,
  output logic                hilo_busy,
  output logic [CW-1:0]       pend_cnt,
  output logic                claim_ovf
);

  // Address-range limit, sized so the compare is width-matched.
  localparam logic [AW:0]   NREG_W     = NREG[AW:0];
  localparam logic [CW-1:0] MAX_PEND_W = MAX_PEND[CW-1:0];

  logic [DW-1:0] r_rf [NREG];
  logic [DW-1:0] r_hi;
  logic [DW-1:0] r_lo;
  logic [CW-1:0] r_pend;
  logic          r_ovf;

  logic          w_gpr_we;
  logic [CW-1:0] w_pend_nxt;
  logic          w_ovf_nxt;

  // Writes to r0 and to addresses past the array are dropped.
  assign w_gpr_we = we && (wa != '0) && ({1'b0, wa} < NREG_W);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else if (w_gpr_we) begin
      r_rf[wa] <= wd;
    end
  end

  // Read ports: r0 and out-of-range addresses read zero; a same-cycle write
  // to the addressed register is forwarded.
  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic          w_valid;
    assign w_ra    = ra[g*AW +: AW];
    assign w_valid = (w_ra != '0) && ({1'b0, w_ra} < NREG_W);
    assign rd[g*DW +: DW] = !w_valid               ? '0 :
                            (we && (wa == w_ra))   ? wd :
                                                     r_rf[w_ra];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (hilo_we[1]) r_hi <= hilo_wd[2*DW-1:DW];
      if (hilo_we[0]) r_lo <= hilo_wd[DW-1:0];
    end
  end

  assign hi_rd = hilo_we[1] ? hilo_wd[2*DW-1:DW] : r_hi;
  assign lo_rd = hilo_we[0] ? hilo_wd[DW-1:0]    : r_lo;

  // Scoreboard: a simultaneous claim and release cancel out, so they never
  // overflow even with the count full; a release at zero is ignored.
  always_comb begin
    w_pend_nxt = r_pend;
    w_ovf_nxt  = 1'b0;
    case ({hilo_claim, hilo_rel})
      2'b10: begin
        if (r_pend == MAX_PEND_W) w_ovf_nxt  = 1'b1;
        else                      w_pend_nxt = r_pend + CW'(1);
      end
      2'b01: begin
        if (r_pend != '0) w_pend_nxt = r_pend - CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pend <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      r_ovf  <= w_ovf_nxt;
    end
  end

  // Busy looks only at the registered count so the stall path stays short;
  // decode therefore stalls one extra cycle after the final release.
  assign hilo_busy = (r_pend != '0);
  assign pend_cnt  = r_pend;
  assign claim_ovf = r_ovf;

endmodule

// File: tb/tb_regfile_hilo_sb.sv
module tb_regfile_hilo_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 2;

  logic            clk;
  logic            resetn;
  logic [2*AW-1:0] ra;
  logic [2*DW-1:0] rd;
  logic            we;
  logic [AW-1:0]   wa;
  logic [DW-1:0]   wd;
  logic [1:0]      hilo_we;
  logic [2*DW-1:0] hilo_wd;
  logic [DW-1:0]   hi_rd;
  logic [DW-1:0]   lo_rd;
  logic            hilo_claim;
  logic            hilo_rel;
  logic            hilo_busy;
  logic [CW-1:0]   pend_cnt;
  logic            claim_ovf;

  int n_chk;
  int n_fail;

  // reference model state for the random phase
  logic [DW-1:0] m_rf [32];
  logic [DW-1:0] m_hi, m_lo;
  int            m_pend;
  logic          m_ovf;

  regfile_hilo_sb #(.DW(32), .NREG(32), .NRD(2), .MAX_PEND(3)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .ra         (ra),
    .rd         (rd),
    .we         (we),
    .wa         (wa),
    .wd         (wd),
    .hilo_we    (hilo_we),
    .hilo_wd    (hilo_wd),
    .hi_rd      (hi_rd),
    .lo_rd      (lo_rd),
    .hilo_claim (hilo_claim),
    .hilo_rel   (hilo_rel),
    .hilo_busy  (hilo_busy),
    .pend_cnt   (pend_cnt),
    .claim_ovf  (claim_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; wa = '0; wd = '0; hilo_we = 2'b00; hilo_wd = '0;
    hilo_claim = 1'b0; hilo_rel = 1'b0;
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (we && wa == a) return wd;
    return m_rf[a];
  endfunction

  initial begin
    n_chk = 0;
    n_fail = 0;
    idle();
    ra = '0;
    resetn = 1'b0;

    // T1: reset state, then a mid-cycle reset wipes loaded state
    #2;
    chk("rst_rd", rd, 64'h0);
    chk("rst_hi", hi_rd, 64'h0);
    chk("rst_lo", lo_rd, 64'h0);
    chk("rst_pend", pend_cnt, 64'h0);
    chk("rst_busy", hilo_busy, 64'h0);
    chk("rst_ovf", claim_ovf, 64'h0);
    #1 resetn = 1'b1;
    tick();
    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
    hilo_we = 2'b10; hilo_wd = {32'h1, 32'h0};
    hilo_claim = 1'b1;
    tick();
    idle();
    hilo_claim = 1'b1;
    tick();
    idle();
    ra = {5'd0, 5'd5};
    #1;
    chk("t1_pre_rd0", rd[31:0], 64'hDEADBEEF);
    chk("t1_pre_hi", hi_rd, 64'h1);
    chk("t1_pre_pend", pend_cnt, 64'h2);
    chk("t1_pre_busy", hilo_busy, 64'h1);
    resetn = 1'b0;
    #1;
    chk("t1_rd", rd, 64'h0);
    chk("t1_hi", hi_rd, 64'h0);
    chk("t1_lo", lo_rd, 64'h0);
    chk("t1_pend", pend_cnt, 64'h0);
    chk("t1_busy", hilo_busy, 64'h0);
    resetn = 1'b1;
    #1;
    chk("t1_after_rd0", rd[31:0], 64'h0);
    tick();

    // T2: write-to-read bypass on both ports, then from the array
    we = 1'b1; wa = 5'd7; wd = 32'h12345678; ra = {5'd7, 5'd7};
    #1;
    chk("t2_byp_rd0", rd[31:0], 64'h12345678);
    chk("t2_byp_rd1", rd[63:32], 64'h12345678);
    tick();
    we = 1'b0; wd = 32'h0;
    #1;
    chk("t2_arr_rd0", rd[31:0], 64'h12345678);
    chk("t2_arr_rd1", rd[63:32], 64'h12345678);
    // bypass only for the matching port
    we = 1'b1; wa = 5'd9; wd = 32'hCAFEF00D; ra = {5'd9, 5'd7};
    #1;
    chk("t2_mix_rd0", rd[31:0], 64'h12345678);
    chk("t2_mix_rd1", rd[63:32], 64'hCAFEF00D);
    tick();

    // T3: register 0 stays zero
    we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; ra = {5'd0, 5'd0};
    #1;
    chk("t3_r0_wcyc0", rd[31:0], 64'h0);
    chk("t3_r0_wcyc1", rd[63:32], 64'h0);
    tick();
    idle();
    #1;
    chk("t3_r0_after", rd[31:0], 64'h0);

    // T4: HI/LO write masks and bypass
    hilo_we = 2'b10; hilo_wd = {32'hAAAA0000, 32'h00005555};
    #1;
    chk("t4_hi_byp", hi_rd, 64'hAAAA0000);
    chk("t4_lo_nobyp", lo_rd, 64'h0);
    tick();
    idle();
    #1;
    chk("t4_hi", hi_rd, 64'hAAAA0000);
    chk("t4_lo", lo_rd, 64'h0);
    hilo_we = 2'b11; hilo_wd = {32'h1, 32'h2};
    #1;
    chk("t4_hi_byp2", hi_rd, 64'h1);
    chk("t4_lo_byp2", lo_rd, 64'h2);
    tick();
    idle();
    #1;
    chk("t4_hi2", hi_rd, 64'h1);
    chk("t4_lo2", lo_rd, 64'h2);
    hilo_we = 2'b01; hilo_wd = {32'h77, 32'h99};
    tick();
    idle();
    #1;
    chk("t4_hi3", hi_rd, 64'h1);
    chk("t4_lo3", lo_rd, 64'h99);

    // T5: scoreboard
    hilo_claim = 1'b1; hilo_rel = 1'b1;
    tick();
    chk("t5_cr_at0", pend_cnt, 64'h0);
    hilo_rel = 1'b0;
    tick();
    chk("t5_c1", pend_cnt, 64'h1);
    chk("t5_c1_busy", hilo_busy, 64'h1);
    tick();
    chk("t5_c2", pend_cnt, 64'h2);
    tick();
    chk("t5_c3", pend_cnt, 64'h3);
    chk("t5_c3_ovf", claim_ovf, 64'h0);
    tick();
    chk("t5_c4", pend_cnt, 64'h3);
    chk("t5_c4_ovf", claim_ovf, 64'h1);
    hilo_rel = 1'b1;
    tick();
    chk("t5_cr_full", pend_cnt, 64'h3);
    chk("t5_cr_ovf", claim_ovf, 64'h0);
    hilo_claim = 1'b0;
    tick();
    chk("t5_r1", pend_cnt, 64'h2);
    tick();
    chk("t5_r2", pend_cnt, 64'h1);
    #1;
    chk("t5_busy_samecyc_rel", hilo_busy, 64'h1);
    tick();
    chk("t5_r3", pend_cnt, 64'h0);
    chk("t5_r3_busy", hilo_busy, 64'h0);
    tick();
    chk("t5_r4", pend_cnt, 64'h0);
    chk("t5_r4_ovf", claim_ovf, 64'h0);
    idle();

    // T6: random traffic against a reference model, starting from reset
    resetn = 1'b0;
    #1 resetn = 1'b1;
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_hi = '0; m_lo = '0; m_pend = 0; m_ovf = 1'b0;
    tick();
    for (int c = 0; c < 10000; c++) begin
      we         = 1'($urandom_range(0, 1));
      wa         = 5'($urandom_range(0, 31));
      wd         = $urandom;
      ra         = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) == 0) ra[4:0] = wa;
      hilo_we    = 2'($urandom_range(0, 3));
      hilo_wd    = {$urandom, $urandom};
      hilo_claim = ($urandom_range(0, 2) != 0);
      hilo_rel   = ($urandom_range(0, 2) == 0);
      #1;
      chk("t6_rd0", rd[31:0], exp_rd(ra[4:0]));
      chk("t6_rd1", rd[63:32], exp_rd(ra[9:5]));
      chk("t6_hi", hi_rd, hilo_we[1] ? hilo_wd[63:32] : m_hi);
      chk("t6_lo", lo_rd, hilo_we[0] ? hilo_wd[31:0] : m_lo);
      chk("t6_pend", pend_cnt, 64'(m_pend));
      chk("t6_ovf", claim_ovf, m_ovf);
      chk("t6_busy", hilo_busy, m_pend != 0);
      n_chk++;
      assert (pend_cnt <= 2'd3) else begin
        n_fail++;
        $error("FAIL t6_pend_max: observed %0d expected <= 3", pend_cnt);
      end
      // model update at the coming edge
      if (we && wa != 0) m_rf[wa] = wd;
      if (hilo_we[1]) m_hi = hilo_wd[63:32];
      if (hilo_we[0]) m_lo = hilo_wd[31:0];
      m_ovf = hilo_claim && !hilo_rel && (m_pend == 3);
      if (hilo_claim && !hilo_rel && m_pend < 3) m_pend = m_pend + 1;
      else if (hilo_rel && !hilo_claim && m_pend > 0) m_pend = m_pend - 1;
      tick();
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
